// File: rtl/axi_reg_seq_master.sv
// Single-beat AXI4 register-access master: runs write / read-check commands over a
// fully handshaked crossbar slave port and reports completion, errors and timeouts.
module axi_reg_seq_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned GAP_CYCLES     = 0,
  localparam int unsigned STRB_W        = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [2:0]                cmd_size_i,
  input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [STRB_W-1:0]         cmd_strb_i,
  input  logic [AXI_DATA_WIDTH-1:0] cmd_rmask_i,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   aw_id_o,
  output logic [2:0]                aw_size_o,
  output logic [7:0]                aw_len_o,
  output logic [1:0]                aw_burst_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0] w_data_o,
  output logic [STRB_W-1:0]         w_strb_o,
  output logic                      w_last_o,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [1:0]                b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   b_id_i,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
  output logic [2:0]                ar_size_o,
  output logic [7:0]                ar_len_o,
  output logic [1:0]                ar_burst_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   r_id_i,
  input  logic                      r_last_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      timeout_o,
  input  logic                      err_clear_i,
  output logic [31:0]               txn_count_o,
  output logic [15:0]               err_count_o
);

  localparam logic [AXI_ID_WIDTH-1:0] IdVal    = AXI_ID_WIDTH'(AXI_ID);
  localparam logic [31:0]             TmoLimit = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0]             GapLimit = 32'(GAP_CYCLES);

  typedef enum logic [2:0] {
    StIdle, StWrite, StWresp, StRaddr, StRdata, StDone, StGap, StHalt
  } state_e;

  state_e                    r_state, w_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [2:0]                r_size;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_strb;
  logic [AXI_DATA_WIDTH-1:0] r_rmask;
  logic                      r_aw_valid, w_aw_valid_nxt;
  logic                      r_w_valid, w_w_valid_nxt;
  logic                      r_ar_valid, w_ar_valid_nxt;
  logic                      r_cmd_err, w_cmd_err_nxt;
  logic                      r_err, w_err_nxt;
  logic                      r_timeout, w_timeout_nxt;
  logic [31:0]               r_txn_count, w_txn_count_nxt;
  logic [15:0]               r_err_count, w_err_count_nxt;
  logic [31:0]               r_tmo_cnt, w_tmo_cnt_nxt;
  logic [31:0]               r_gap_cnt, w_gap_cnt_nxt;

  logic w_accept;
  logic w_active;
  logic w_complete;
  logic w_set_err;
  logic w_rd_mismatch;

  assign w_accept      = cmd_valid_i && (r_state == StIdle);
  assign w_active      = (r_state == StWrite) || (r_state == StWresp) ||
                         (r_state == StRaddr) || (r_state == StRdata);
  assign w_rd_mismatch = |((r_data_i ^ r_wdata) & r_rmask);

  always_comb begin
    w_state_nxt    = r_state;
    w_aw_valid_nxt = r_aw_valid;
    w_w_valid_nxt  = r_w_valid;
    w_ar_valid_nxt = r_ar_valid;
    w_cmd_err_nxt  = r_cmd_err;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_timeout_nxt  = r_timeout;
    w_complete     = 1'b0;
    w_set_err      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_cmd_err_nxt = 1'b0;
          w_tmo_cnt_nxt = '0;
          if (cmd_we_i) begin
            w_state_nxt    = StWrite;
            w_aw_valid_nxt = 1'b1;
            w_w_valid_nxt  = 1'b1;
          end else begin
            w_state_nxt    = StRaddr;
            w_ar_valid_nxt = 1'b1;
          end
        end
      end
      StWrite: begin
        w_aw_valid_nxt = r_aw_valid && !aw_ready_i;
        w_w_valid_nxt  = r_w_valid && !w_ready_i;
        if (!w_aw_valid_nxt && !w_w_valid_nxt) w_state_nxt = StWresp;
      end
      StWresp: begin
        if (b_valid_i) begin
          w_complete  = 1'b1;
          w_state_nxt = StDone;
          if ((b_resp_i != 2'b00) || (b_id_i != IdVal)) w_cmd_err_nxt = 1'b1;
        end
      end
      StRaddr: begin
        if (ar_ready_i) begin
          w_ar_valid_nxt = 1'b0;
          w_state_nxt    = StRdata;
        end
      end
      StRdata: begin
        if (r_valid_i) begin
          w_complete  = 1'b1;
          w_state_nxt = StDone;
          if ((r_resp_i != 2'b00) || (r_id_i != IdVal) || !r_last_i || w_rd_mismatch) begin
            w_cmd_err_nxt = 1'b1;
          end
        end
      end
      StDone: begin
        w_set_err     = r_cmd_err;
        w_gap_cnt_nxt = '0;
        w_state_nxt   = (GAP_CYCLES > 0) ? StGap : StIdle;
      end
      StGap: begin
        if (r_gap_cnt + 32'd1 >= GapLimit) w_state_nxt = StIdle;
        else                               w_gap_cnt_nxt = r_gap_cnt + 32'd1;
      end
      StHalt: begin
        // Outstanding valids may still complete their handshake; nothing new is issued.
        w_aw_valid_nxt = r_aw_valid && !aw_ready_i;
        w_w_valid_nxt  = r_w_valid && !w_ready_i;
        w_ar_valid_nxt = r_ar_valid && !ar_ready_i;
      end
      default: w_state_nxt = StIdle;
    endcase

    // A response handshake landing on the limit cycle still counts as completion.
    if (w_active && (TIMEOUT_CYCLES != 0)) begin
      w_tmo_cnt_nxt = r_tmo_cnt + 32'd1;
      if (!w_complete && (w_tmo_cnt_nxt == TmoLimit)) begin
        w_state_nxt   = StHalt;
        w_timeout_nxt = 1'b1;
        w_set_err     = 1'b1;
      end
    end
  end

  always_comb begin
    w_txn_count_nxt = (r_state == StDone) ? r_txn_count + 32'd1 : r_txn_count;
    w_err_count_nxt = err_clear_i ? 16'h0 : r_err_count;
    if (w_set_err && (w_err_count_nxt != 16'hFFFF)) w_err_count_nxt = w_err_count_nxt + 16'd1;
    w_err_nxt = w_set_err ? 1'b1 : (err_clear_i ? 1'b0 : r_err);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_rmask     <= '0;
      r_aw_valid  <= 1'b0;
      r_w_valid   <= 1'b0;
      r_ar_valid  <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_txn_count <= '0;
      r_err_count <= '0;
      r_tmo_cnt   <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_aw_valid  <= w_aw_valid_nxt;
      r_w_valid   <= w_w_valid_nxt;
      r_ar_valid  <= w_ar_valid_nxt;
      r_cmd_err   <= w_cmd_err_nxt;
      r_err       <= w_err_nxt;
      r_timeout   <= w_timeout_nxt;
      r_txn_count <= w_txn_count_nxt;
      r_err_count <= w_err_count_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      if (w_accept) begin
        r_addr  <= cmd_addr_i;
        r_size  <= cmd_size_i;
        r_wdata <= cmd_wdata_i;
        r_strb  <= cmd_strb_i;
        r_rmask <= cmd_rmask_i;
      end
    end
  end

  assign cmd_ready_o = (r_state == StIdle);
  assign busy_o      = (r_state != StIdle);
  assign done_o      = (r_state == StDone);
  assign err_o       = r_err;
  assign timeout_o   = r_timeout;
  assign txn_count_o = r_txn_count;
  assign err_count_o = r_err_count;

  assign aw_valid_o = r_aw_valid;
  assign aw_addr_o  = r_addr;
  assign aw_id_o    = IdVal;
  assign aw_size_o  = r_size;
  assign aw_len_o   = 8'h00;
  assign aw_burst_o = 2'b01;
  assign w_valid_o  = r_w_valid;
  assign w_data_o   = r_wdata;
  assign w_strb_o   = r_strb;
  assign w_last_o   = 1'b1;
  assign b_ready_o  = (r_state == StWresp) || (r_state == StHalt);
  assign ar_valid_o = r_ar_valid;
  assign ar_addr_o  = r_addr;
  assign ar_id_o    = IdVal;
  assign ar_size_o  = r_size;
  assign ar_len_o   = 8'h00;
  assign ar_burst_o = 2'b01;
  assign r_ready_o  = (r_state == StRdata) || (r_state == StHalt);

endmodule

// File: doc/axi_reg_seq_master.md
Name: axi_reg_seq_master

Overview:
- Parametrised AXI4 single-beat register-access master for SoC-level simulation tops and bring-up.
- Replaces hard-coded, counter-timed writes into the crossbar slave port, which ignore ready signals.
- Accepts a stream of write / read-check commands and drives a crossbar slave port with a fully handshaked AW/W/B and AR/R protocol.
- Reports completion, response errors, read-data mismatches and timeouts.

Parameters:
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width; STRB_W = AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 4, ID width.
- AXI_ID, 0, fixed ID driven on aw_id_o/ar_id_o and expected on b_id_i/r_id_i.
- TIMEOUT_CYCLES, 256, maximum cycles from command accept to response handshake; 0 disables the timeout.
- GAP_CYCLES, 0, idle cycles inserted after each completed command.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: asynchronous active-low reset.
- cmd_valid_i in 1: command valid.
- cmd_ready_o out 1: command accepted when cmd_valid_i & cmd_ready_o.
- cmd_we_i in 1: 1 = write, 0 = read-check.
- cmd_addr_i in AXI_ADDR_WIDTH: target address.
- cmd_size_i in 3: AXI size.
- cmd_wdata_i in AXI_DATA_WIDTH: write data, or expected read data.
- cmd_strb_i in STRB_W: write strobes.
- cmd_rmask_i in AXI_DATA_WIDTH: read compare mask; 0 = no check.
- aw_valid_o out 1, aw_ready_i in 1, aw_addr_o out AXI_ADDR_WIDTH, aw_id_o out AXI_ID_WIDTH, aw_size_o out 3, aw_len_o out 8, aw_burst_o out 2: AW channel.
- w_valid_o out 1, w_ready_i in 1, w_data_o out AXI_DATA_WIDTH, w_strb_o out STRB_W, w_last_o out 1: W channel.
- b_valid_i in 1, b_ready_o out 1, b_resp_i in 2, b_id_i in AXI_ID_WIDTH: B channel.
- ar_valid_o out 1, ar_ready_i in 1, ar_addr_o out AXI_ADDR_WIDTH, ar_id_o out AXI_ID_WIDTH, ar_size_o out 3, ar_len_o out 8, ar_burst_o out 2: AR channel.
- r_valid_i in 1, r_ready_o out 1, r_data_i in AXI_DATA_WIDTH, r_resp_i in 2, r_id_i in AXI_ID_WIDTH, r_last_i in 1: R channel.
- busy_o out 1: state != IDLE.
- done_o out 1: one-cycle pulse per completed command.
- err_o out 1: sticky OR of all error sources.
- timeout_o out 1: sticky timeout flag.
- err_clear_i in 1: clears err_o and err_count_o; does not clear timeout_o.
- txn_count_o out 32: completed commands.
- err_count_o out 16: erroneous commands; saturates at 0xFFFF.

Behaviour:
- Reset state: all valid/ready outputs 0, addr/data/strb/size/id outputs 0, busy_o/done_o/err_o/timeout_o 0, counters 0, state IDLE.
- Constant outputs: aw_len_o/ar_len_o = 0, aw_burst_o/ar_burst_o = 2'b01, w_last_o = 1.
- Command capture: cmd_ready_o = 1 only in IDLE. On accept, all command fields are registered. AXI payload outputs come from these registers and are held stable while the corresponding valid is high.
- IDLE:
  - Write accept → WRITE; aw_valid_o and w_valid_o assert the next cycle.
  - Read accept → RADDR; ar_valid_o asserts the next cycle.
- WRITE:
  - aw_valid_o and w_valid_o deassert independently on their own handshakes. AW first, W first, or both in the same cycle are all legal.
  - Both handshakes done → WRESP.
  - Valids are never withdrawn before their handshake.
- WRESP:
  - b_ready_o = 1. On b_valid_i → DONE.
  - Error if b_resp_i != 2'b00 or b_id_i != AXI_ID.
- RADDR: ar_valid_o held until ar_ready_i → RDATA.
- RDATA:
  - r_ready_o = 1. On r_valid_i → DONE.
  - Error if r_resp_i != 0, r_id_i != AXI_ID, r_last_i == 0, or ((r_data_i ^ wdata_q) & rmask_q) != 0.
- DONE (1 cycle):
  - done_o = 1; txn_count_o increments (wraps).
  - If the command had an error: err_o set and err_count_o increments (saturating).
  - Next state: GAP if GAP_CYCLES > 0, else IDLE.
- GAP: counts GAP_CYCLES cycles, then → IDLE.
- Timeout:
  - Counter clears on command accept and increments every cycle in WRITE/WRESP/RADDR/RDATA.
  - Reaching TIMEOUT_CYCLES → HALT: timeout_o = 1, err_o = 1, err_count_o increments.
  - In HALT, already-asserted valids stay asserted (AXI rule), b_ready_o/r_ready_o stay 1 to drain late responses, cmd_ready_o = 0.
  - Only reset leaves HALT.
- err_clear_i coinciding with an error-setting event: the set wins.
- Reset mid-transaction: asynchronous return to the reset state; no completion pulse is generated.

Test Plan:
- Write 0x5000_0010 / 0x9000_0004, strb 0xFF, with aw_ready and w_ready tied 1 and b_valid one cycle later → aw_valid/w_valid high exactly 1 cycle, done_o pulse, txn_count_o = 1, err_o = 0.
- Write 0x5000_0020 / 0x2424_4242 with w_ready delayed 5 cycles after aw_ready → aw_valid drops after 1 cycle, w_valid held 6 cycles with stable data, single B handshake, done_o once.
- Read-check 0x9000_0004, expected 0x2424_4242, mask 0xFFFF_FFFF, returned 0x2424_4242 → no error. Returned 0x2424_4243 → err_o = 1, err_count_o = 1.
- Write with b_resp = SLVERR (2'b10) → err_o = 1 and the next command still accepted. Pulse err_clear_i → err_o = 0, err_count_o = 0.
- TIMEOUT_CYCLES = 16, aw_ready held 0 → timeout_o = 1 at cycle 16 after accept, aw_valid_o still 1, cmd_ready_o stays 0. rst_ni low → all outputs return to reset values.
- GAP_CYCLES = 3 with back-to-back writes to 0x5000_0010, 0x5000_0020, 0x5000_0028 → cmd_ready_o reasserts exactly 4 cycles after each done_o, txn_count_o = 3.
